data_mem_arbiter: RTL and testbench
===================================

# data_mem_arbiter

Shares the single-port data RAM (`sp_ram_wrap`) between `NUM_PORTS` requesters. Examples are the AXI slave bridge and a DMA or debug master. Arbitration is round-robin, with an optional bounded lock for atomic read-modify-write sequences. Out-of-range addresses are rejected with an error response and never reach the RAM. The block sits between the requesters' memory-request ports and the RAM instance inside the data-memory subsystem.

## Interface
- `NUM_PORTS`, 2: number of requesters, 2..4.
- `ADDR_WIDTH`, 32: requester address width (byte address).
- `DATA_WIDTH`, 32: data width; `BE_WIDTH = DATA_WIDTH/8`.
- `RAM_SIZE`, 65536: RAM size in bytes; `MEM_ADDR_WIDTH = $clog2(RAM_SIZE)`.
- `MAX_LOCK`, 4: maximum consecutive grants to one locked requester.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `req_i`  in  NUM_PORTS  per-port request.
- `lock_i`  in  NUM_PORTS  per-port lock request, sampled with a granted request.
- `we_i`  in  NUM_PORTS  per-port write enable.
- `addr_i`  in  NUM_PORTS*ADDR_WIDTH  packed addresses; port k occupies bits [k*ADDR_WIDTH +: ADDR_WIDTH].
- `be_i`  in  NUM_PORTS*BE_WIDTH  packed byte enables.
- `wdata_i`  in  NUM_PORTS*DATA_WIDTH  packed write data.
- `gnt_o`  out  NUM_PORTS  one-hot grant, combinational, same cycle as the request.
- `rvalid_o`  out  NUM_PORTS  one-hot response, one cycle after the grant.
- `rdata_o`  out  DATA_WIDTH  shared response data, meaningful only while some `rvalid_o` bit is high.
- `err_o`  out  1  response error flag, qualified by `rvalid_o`.
- `mem_en_o`  out  1  RAM enable.
- `mem_we_o`  out  1  RAM write enable.
- `mem_addr_o`  out  MEM_ADDR_WIDTH  RAM byte address.
- `mem_be_o`  out  BE_WIDTH  RAM byte enables.
- `mem_wdata_o`  out  DATA_WIDTH  RAM write data.
- `mem_rdata_i`  in  DATA_WIDTH  RAM read data, valid one cycle after `mem_en_o`.

## Operation
- **Request handshake.**
  - A request transfers in the cycle where `req_i[k] && gnt_o[k]`.
  - A requester holds `req_i`, `we_i`, `addr_i`, `be_i` and `wdata_i` stable until it is granted.
  - At most one grant per cycle. With no requests, `gnt_o` is 0 and `mem_en_o` is 0.
- **Round-robin.**
  - Register `rr_ptr` (`$clog2(NUM_PORTS)` bits) holds the highest-priority port.
  - Priority order is `rr_ptr, rr_ptr+1, ...`, modulo `NUM_PORTS`.
  - After a grant to port g in state `ARB`, `rr_ptr <= (g+1) mod NUM_PORTS`.
- **Range check.**
  - A request is in range iff `addr_i[k][ADDR_WIDTH-1:MEM_ADDR_WIDTH] == 0`.
  - A granted out-of-range request holds `mem_en_o` at 0. The next cycle it returns `rvalid_o[g]=1`, `err_o=1`, `rdata_o=0`.
  - A write is discarded.
- **Memory drive.** For a granted in-range request, `mem_en_o=1` and the `mem_*` outputs mirror port g's fields truncated to `MEM_ADDR_WIDTH`. This is combinational, in the same cycle as the grant.
- **Response.**
  - Registered `resp_port` (one-hot) and `resp_err` drive `rvalid_o` and `err_o`.
  - `rdata_o = mem_rdata_i` when `!resp_err`, else 0.
  - Writes also get an `rvalid`; its `rdata` is don't-care.
- **State machine.** States are `ARB` and `LOCKED`; register `lock_owner` plus a lock counter `lock_cnt` (`$clog2(MAX_LOCK+1)` bits).
  - `ARB` → `LOCKED`: a grant to g with `lock_i[g]=1`. Set `lock_owner=g`, `lock_cnt=1`.
  - In `LOCKED`, only `lock_owner` may be granted. Every other port sees `gnt=0`, even when the owner is idle.
  - Each owner grant increments `lock_cnt`.
  - `LOCKED` → `ARB` when any of the following holds:
    - the owner is granted with `lock_i=0` (that grant still completes);
    - the owner has `req_i=0` (no grant that cycle);
    - a grant brings `lock_cnt` to `MAX_LOCK`.
  - On every exit from `LOCKED`, `rr_ptr <= (lock_owner+1) mod NUM_PORTS`. This guarantees the other ports win next.
  - `lock_i` on an out-of-range request is honoured like any other lock.

## Timing
- Reset values: `rr_ptr=0`, state `ARB`, `lock_cnt=0`, `resp_port=0`, `resp_err=0`.
  - Hence `rvalid_o=0` and `err_o=0` during and after reset. `gnt_o` and `mem_en_o` are 0 while `rst_n=0`.
- Reset mid-operation: a pending response is dropped, with no `rvalid` after reset deasserts, and any lock is released.
- Throughput: one transfer per cycle. Back-to-back grants to different ports are allowed.
- Latency: `gnt` to `rvalid` is exactly 1 cycle.
- Starvation bound: a requesting port is granted within `(NUM_PORTS-1)*MAX_LOCK + NUM_PORTS` cycles.
- No combinational path from `mem_rdata_i` to `gnt_o`.

## Structure
- Package `data_mem_arb_pkg` holds:
  - the `arb_state_e` enum (`ARB`, `LOCKED`);
  - the function `rr_pick(req, rr_ptr)`, which returns a one-hot grant;
  - the localparam helpers for `BE_WIDTH` and `MEM_ADDR_WIDTH`.
- One sub-module: `data_mem_rr_pick`, the combinational rotate-priority-rotate-back picker (`NUM_PORTS` parameter).
- The top module holds the FSM, `rr_ptr`, range check, mux and response registers.

## Test plan
- Single read: port 0 reads `0x0000_0100` with the RAM preloaded to `0xDEADBEEF` → same-cycle `gnt_o=01`, `mem_en_o=1`, `mem_addr_o=0x0100`; next cycle `rvalid_o=01`, `rdata_o=0xDEADBEEF`, `err_o=0`.
- Contention: both ports request continuously for 6 cycles starting with `rr_ptr=0` → grants alternate 01,10,01,10,01,10; each `rvalid` follows its grant by one cycle.
- Out of range: port 1 writes `0x1013_0000` with `be=0xF` → `gnt_o=10`, `mem_en_o=0`; next cycle `rvalid_o=10`, `err_o=1`, `rdata_o=0`; RAM contents unchanged.
- Lock bound: port 0 holds `req` and `lock` for 8 cycles while port 1 requests → port 0 is granted cycles 0–3 (`MAX_LOCK=4`), port 1 in cycle 4, port 0 again in cycle 5.
- Lock release: port 0 locks, then drops `req` for 1 cycle while port 1 requests → port 1 is granted in the cycle after the drop, not the drop cycle itself.
- Reset mid-read: assert `rst_n=0` in the cycle after a read grant → no `rvalid` during or after reset; state `ARB`, `rr_ptr=0`; the next request from port 1 alone is granted immediately.

Source files
------------

// File: rtl/data_mem_arb_pkg.sv
// Shared types and helpers for the data-memory arbiter: FSM states, width
// helpers and the round-robin pick function used by the picker sub-module.
package data_mem_arb_pkg;

    typedef enum logic [0:0] {
        ARB    = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

    localparam int unsigned MAX_PORTS = 4;

    function automatic int unsigned be_width(input int unsigned data_width);
        return data_width / 8;
    endfunction

    function automatic int unsigned mem_addr_width(input int unsigned ram_size);
        return $clog2(ram_size);
    endfunction

    // Walks ports in priority order rr_ptr, rr_ptr+1, ... (mod num_ports) and
    // returns the first requester as a one-hot vector.
    function automatic logic [MAX_PORTS-1:0] rr_pick(
        input logic [MAX_PORTS-1:0] req,
        input logic [1:0]           rr_ptr,
        input int unsigned          num_ports
    );
        logic [MAX_PORTS-1:0] gnt;
        logic                 found;
        int unsigned          idx;
        gnt   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < MAX_PORTS; i++) begin
            idx = rr_ptr;
            idx = (idx + i) % num_ports;
            if (i < num_ports && !found && req[idx[1:0]]) begin
                gnt[idx[1:0]] = 1'b1;
                found         = 1'b1;
            end
        end
        return gnt;
    endfunction

endpackage

// File: rtl/data_mem_rr_pick.sv
// Combinational round-robin picker: one-hot grant of the first requester at
// or after rr_ptr, wrapping modulo NUM_PORTS.
module data_mem_rr_pick
    import data_mem_arb_pkg::*;
#(
    parameter  int unsigned NUM_PORTS = 2,
    localparam int unsigned PTR_W     = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [PTR_W-1:0]     rr_ptr,
    output logic [NUM_PORTS-1:0] gnt
);

    assign gnt = NUM_PORTS'(rr_pick(MAX_PORTS'(req), 2'(rr_ptr), NUM_PORTS));

endmodule

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing the single-port data RAM between requesters,
// with a bounded lock for atomic sequences and out-of-range rejection.
module data_mem_arbiter
    import data_mem_arb_pkg::*;
#(
    parameter  int unsigned NUM_PORTS      = 2,
    parameter  int unsigned ADDR_WIDTH     = 32,
    parameter  int unsigned DATA_WIDTH     = 32,
    parameter  int unsigned RAM_SIZE       = 65536,
    parameter  int unsigned MAX_LOCK       = 4,
    localparam int unsigned BE_WIDTH       = be_width(DATA_WIDTH),
    localparam int unsigned MEM_ADDR_WIDTH = mem_addr_width(RAM_SIZE)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_PORTS-1:0]            req_i,
    input  logic [NUM_PORTS-1:0]            lock_i,
    input  logic [NUM_PORTS-1:0]            we_i,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] addr_i,
    input  logic [NUM_PORTS*BE_WIDTH-1:0]   be_i,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] wdata_i,
    output logic [NUM_PORTS-1:0]            gnt_o,
    output logic [NUM_PORTS-1:0]            rvalid_o,
    output logic [DATA_WIDTH-1:0]           rdata_o,
    output logic                            err_o,
    output logic                            mem_en_o,
    output logic                            mem_we_o,
    output logic [MEM_ADDR_WIDTH-1:0]       mem_addr_o,
    output logic [BE_WIDTH-1:0]             mem_be_o,
    output logic [DATA_WIDTH-1:0]           mem_wdata_o,
    input  logic [DATA_WIDTH-1:0]           mem_rdata_i
);

    localparam int unsigned PTR_W = $clog2(NUM_PORTS);
    localparam int unsigned CNT_W = $clog2(MAX_LOCK + 1);

    logic [ADDR_WIDTH-1:0] addr_arr  [NUM_PORTS];
    logic [BE_WIDTH-1:0]   be_arr    [NUM_PORTS];
    logic [DATA_WIDTH-1:0] wdata_arr [NUM_PORTS];
    logic [NUM_PORTS-1:0]  in_range;

    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
            assign addr_arr[gi]  = addr_i[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign be_arr[gi]    = be_i[gi*BE_WIDTH +: BE_WIDTH];
            assign wdata_arr[gi] = wdata_i[gi*DATA_WIDTH +: DATA_WIDTH];
            assign in_range[gi]  = (addr_arr[gi] >> MEM_ADDR_WIDTH) == '0;
        end
    endgenerate

    arb_state_e           state_reg, state_next;
    logic [PTR_W-1:0]     rr_ptr_reg, rr_ptr_next;
    logic [PTR_W-1:0]     lock_owner_reg, lock_owner_next;
    logic [CNT_W-1:0]     lock_cnt_reg, lock_cnt_next;
    logic [NUM_PORTS-1:0] resp_port_reg;
    logic                 resp_err_reg;

    logic [NUM_PORTS-1:0] pick_gnt;
    logic [PTR_W-1:0]     pick_idx;
    logic [NUM_PORTS-1:0] gnt;

    data_mem_rr_pick #(
        .NUM_PORTS (NUM_PORTS)
    ) u_rr_pick (
        .req    (req_i),
        .rr_ptr (rr_ptr_reg),
        .gnt    (pick_gnt)
    );

    function automatic logic [PTR_W-1:0] next_port(input logic [PTR_W-1:0] p);
        return (32'(p) == NUM_PORTS - 1) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        pick_idx = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (pick_gnt[k]) pick_idx = PTR_W'(k);
        end
    end

    always_comb begin
        state_next      = state_reg;
        rr_ptr_next     = rr_ptr_reg;
        lock_owner_next = lock_owner_reg;
        lock_cnt_next   = lock_cnt_reg;
        gnt             = '0;
        unique case (state_reg)
            ARB: begin
                if (|pick_gnt) begin
                    gnt         = pick_gnt;
                    rr_ptr_next = next_port(pick_idx);
                    if (lock_i[pick_idx] && MAX_LOCK > 1) begin
                        state_next      = LOCKED;
                        lock_owner_next = pick_idx;
                        lock_cnt_next   = CNT_W'(1);
                    end
                end
            end
            LOCKED: begin
                // Non-owners stay blocked even while the owner is idle; every
                // exit hands priority to the port after the owner.
                if (req_i[lock_owner_reg]) begin
                    gnt[lock_owner_reg] = 1'b1;
                    if (!lock_i[lock_owner_reg] || (32'(lock_cnt_reg) + 1 >= MAX_LOCK)) begin
                        state_next    = ARB;
                        rr_ptr_next   = next_port(lock_owner_reg);
                        lock_cnt_next = '0;
                    end else begin
                        lock_cnt_next = lock_cnt_reg + CNT_W'(1);
                    end
                end else begin
                    state_next    = ARB;
                    rr_ptr_next   = next_port(lock_owner_reg);
                    lock_cnt_next = '0;
                end
            end
            default: state_next = ARB;
        endcase
        if (!rst_n) gnt = '0;
    end

    assign gnt_o = gnt;

    always_comb begin
        mem_en_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_be_o    = '0;
        mem_wdata_o = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (gnt[k]) begin
                mem_en_o    = in_range[k];
                mem_we_o    = we_i[k] & in_range[k];
                mem_addr_o  = addr_arr[k][MEM_ADDR_WIDTH-1:0];
                mem_be_o    = be_arr[k];
                mem_wdata_o = wdata_arr[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= ARB;
            rr_ptr_reg     <= '0;
            lock_owner_reg <= '0;
            lock_cnt_reg   <= '0;
            resp_port_reg  <= '0;
            resp_err_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            rr_ptr_reg     <= rr_ptr_next;
            lock_owner_reg <= lock_owner_next;
            lock_cnt_reg   <= lock_cnt_next;
            resp_port_reg  <= gnt;
            resp_err_reg   <= |(gnt & ~in_range);
        end
    end

    // Gated by rst_n so a response pending when reset arrives is never seen.
    assign rvalid_o = rst_n ? resp_port_reg : '0;
    assign err_o    = rst_n & resp_err_reg;
    assign rdata_o  = resp_err_reg ? '0 : mem_rdata_i;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed self-checking bench for data_mem_arbiter with a behavioural
// single-port RAM (registered read, byte-enabled write) attached.
module tb_data_mem_arbiter;

    localparam int N   = 2;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int BW  = 4;
    localparam int MAW = 16;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    req = '0, lock = '0, we = '0;
    logic [N*AW-1:0] addr = '0;
    logic [N*BW-1:0] be = '0;
    logic [N*DW-1:0] wdata = '0;
    logic [N-1:0]    gnt, rvalid;
    logic [DW-1:0]   rdata;
    logic            err, mem_en, mem_we;
    logic [MAW-1:0]  mem_addr;
    logic [BW-1:0]   mem_be;
    logic [DW-1:0]   mem_wdata;
    logic [DW-1:0]   mem_rdata;

    logic [DW-1:0]   ram [0:16383];
    logic            poke_en = 1'b0;
    logic [13:0]     poke_idx = '0;
    logic [DW-1:0]   poke_data = '0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_mem_arbiter #(
        .NUM_PORTS (N),
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW),
        .RAM_SIZE  (65536),
        .MAX_LOCK  (4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_i      (req),
        .lock_i     (lock),
        .we_i       (we),
        .addr_i     (addr),
        .be_i       (be),
        .wdata_i    (wdata),
        .gnt_o      (gnt),
        .rvalid_o   (rvalid),
        .rdata_o    (rdata),
        .err_o      (err),
        .mem_en_o   (mem_en),
        .mem_we_o   (mem_we),
        .mem_addr_o (mem_addr),
        .mem_be_o   (mem_be),
        .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata)
    );

    always @(posedge clk) begin
        if (poke_en) begin
            ram[poke_idx] <= poke_data;
        end else if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < BW; b++)
                    if (mem_be[b]) ram[mem_addr[15:2]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
            end else begin
                mem_rdata <= ram[mem_addr[15:2]];
            end
        end
    end

    task automatic drive(input int k, input logic r, input logic l, input logic w,
                         input logic [31:0] a, input logic [3:0] b, input logic [31:0] d);
        req[k] = r; lock[k] = l; we[k] = w;
        addr[k*AW +: AW] = a; be[k*BW +: BW] = b; wdata[k*DW +: DW] = d;
    endtask

    task automatic idle();
        req = '0; lock = '0; we = '0; addr = '0; be = '0; wdata = '0;
    endtask

    task automatic poke(input logic [13:0] idx, input logic [31:0] d);
        poke_en = 1'b1; poke_idx = idx; poke_data = d;
        @(negedge clk);
        poke_en = 1'b0;
    endtask

    // Single port-1 grant so the round-robin pointer lands on port 0.
    task automatic set_ptr0();
        drive(1, 1'b1, 1'b0, 1'b0, 32'h0, 4'hF, 32'h0);
        @(negedge clk);
        idle();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(0, 1'b1, 1'b0, 1'b0, 32'h100, 4'hF, 32'h0);
        drive(1, 1'b1, 1'b0, 1'b0, 32'h104, 4'hF, 32'h0);
        repeat (2) @(negedge clk);
        #1;
        checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL reset_gnt got=%b exp=%b", gnt, 2'b00); end
        checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL reset_mem_en got=%b exp=0", mem_en); end
        checks++; if (rvalid !== 2'b00) begin errors++; $display("FAIL reset_rvalid got=%b exp=%b", rvalid, 2'b00); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got=%b exp=0", err); end
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        #1;
        checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL idle_gnt got=%b exp=%b", gnt, 2'b00); end
        checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL idle_mem_en got=%b exp=0", mem_en); end
        checks++; if (rvalid !== 2'b00) begin errors++; $display("FAIL post_reset_rvalid got=%b exp=%b", rvalid, 2'b00); end
        @(negedge clk);
        $display("test_reset done");
    endtask

    task automatic test_single_read();
        poke(14'h040, 32'hDEADBEEF);
        drive(0, 1'b1, 1'b0, 1'b0, 32'h0000_0100, 4'hF, 32'h0);
        #1;
        checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL read_gnt got=%b exp=%b", gnt, 2'b01); end
        checks++; if (mem_en !== 1'b1) begin errors++; $display("FAIL read_mem_en got=%b exp=1", mem_en); end
        checks++; if (mem_addr !== 16'h0100) begin errors++; $display("FAIL read_mem_addr got=%h exp=0100", mem_addr); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL read_mem_we got=%b exp=0", mem_we); end
        @(negedge clk);
        idle();
        #1;
        checks++; if (rvalid !== 2'b01) begin errors++; $display("FAIL read_rvalid got=%b exp=%b", rvalid, 2'b01); end
        checks++; if (rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL read_rdata got=%h exp=deadbeef", rdata); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL read_err got=%b exp=0", err); end
        @(negedge clk);
        $display("test_single_read done");
    endtask

    task automatic test_contention();
        logic [1:0]  exp_g, prev_g;
        logic [31:0] exp_d;
        poke(14'h080, 32'h1111_1111);
        poke(14'h081, 32'h2222_2222);
        set_ptr0();
        drive(0, 1'b1, 1'b0, 1'b0, 32'h200, 4'hF, 32'h0);
        drive(1, 1'b1, 1'b0, 1'b0, 32'h204, 4'hF, 32'h0);
        prev_g = 2'b00;
        for (int i = 0; i < 6; i++) begin
            exp_g = (i % 2 == 0) ? 2'b01 : 2'b10;
            #1;
            checks++; if (gnt !== exp_g) begin errors++; $display("FAIL contention_gnt[%0d] got=%b exp=%b", i, gnt, exp_g); end
            if (i > 0) begin
                exp_d = (prev_g == 2'b01) ? 32'h1111_1111 : 32'h2222_2222;
                checks++; if (rvalid !== prev_g) begin errors++; $display("FAIL contention_rvalid[%0d] got=%b exp=%b", i, rvalid, prev_g); end
                checks++; if (rdata !== exp_d) begin errors++; $display("FAIL contention_rdata[%0d] got=%h exp=%h", i, rdata, exp_d); end
            end
            prev_g = exp_g;
            @(negedge clk);
        end
        idle();
        #1;
        checks++; if (rvalid !== 2'b10) begin errors++; $display("FAIL contention_last_rvalid got=%b exp=%b", rvalid, 2'b10); end
        checks++; if (rdata !== 32'h2222_2222) begin errors++; $display("FAIL contention_last_rdata got=%h exp=22222222", rdata); end
        @(negedge clk);
        $display("test_contention done");
    endtask

    task automatic test_out_of_range();
        poke(14'h000, 32'hA5A5_A5A5);
        drive(1, 1'b1, 1'b0, 1'b1, 32'h1013_0000, 4'hF, 32'h1234_5678);
        #1;
        checks++; if (gnt !== 2'b10) begin errors++; $display("FAIL oor_gnt got=%b exp=%b", gnt, 2'b10); end
        checks++; if (mem_en !== 1'b0) begin errors++; $display("FAIL oor_mem_en got=%b exp=0", mem_en); end
        @(negedge clk);
        idle();
        #1;
        checks++; if (rvalid !== 2'b10) begin errors++; $display("FAIL oor_rvalid got=%b exp=%b", rvalid, 2'b10); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL oor_err got=%b exp=1", err); end
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL oor_rdata got=%h exp=00000000", rdata); end
        checks++; if (ram[0] !== 32'hA5A5_A5A5) begin errors++; $display("FAIL oor_ram got=%h exp=a5a5a5a5", ram[0]); end
        @(negedge clk);
        $display("test_out_of_range done");
    endtask

    task automatic test_write_readback();
        poke(14'h0C0, 32'h1122_3344);
        drive(0, 1'b1, 1'b0, 1'b1, 32'h300, 4'b0011, 32'hCAFE_F00D);
        #1;
        checks++; if (mem_en !== 1'b1 || mem_we !== 1'b1) begin errors++; $display("FAIL wr_mem_en_we got=%b%b exp=11", mem_en, mem_we); end
        checks++; if (mem_be !== 4'b0011) begin errors++; $display("FAIL wr_mem_be got=%b exp=0011", mem_be); end
        checks++; if (mem_wdata !== 32'hCAFE_F00D) begin errors++; $display("FAIL wr_mem_wdata got=%h exp=cafef00d", mem_wdata); end
        checks++; if (mem_addr !== 16'h0300) begin errors++; $display("FAIL wr_mem_addr got=%h exp=0300", mem_addr); end
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 1'b0, 32'h300, 4'hF, 32'h0);
        #1;
        checks++; if (rvalid !== 2'b01 || err !== 1'b0) begin errors++; $display("FAIL wr_rvalid_err got=%b/%b exp=01/0", rvalid, err); end
        checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL rb_gnt got=%b exp=%b", gnt, 2'b01); end
        @(negedge clk);
        idle();
        #1;
        checks++; if (rdata !== 32'h1122_F00D) begin errors++; $display("FAIL rb_rdata got=%h exp=1122f00d", rdata); end
        @(negedge clk);
        $display("test_write_readback done");
    endtask

    task automatic test_lock_bound();
        logic [1:0] exp_tab [8];
        logic [1:0] prev_g;
        exp_tab = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b01};
        set_ptr0();
        drive(0, 1'b1, 1'b1, 1'b0, 32'h100, 4'hF, 32'h0);
        drive(1, 1'b1, 1'b0, 1'b0, 32'h204, 4'hF, 32'h0);
        prev_g = 2'b00;
        for (int i = 0; i < 8; i++) begin
            #1;
            checks++; if (gnt !== exp_tab[i]) begin errors++; $display("FAIL lock_bound_gnt[%0d] got=%b exp=%b", i, gnt, exp_tab[i]); end
            if (i > 0) begin
                checks++; if (rvalid !== prev_g) begin errors++; $display("FAIL lock_bound_rvalid[%0d] got=%b exp=%b", i, rvalid, prev_g); end
            end
            prev_g = exp_tab[i];
            @(negedge clk);
        end
        idle();
        #1;
        checks++; if (rvalid !== 2'b01) begin errors++; $display("FAIL lock_bound_last_rvalid got=%b exp=%b", rvalid, 2'b01); end
        @(negedge clk);
        $display("test_lock_bound done");
    endtask

    task automatic test_lock_release();
        set_ptr0();
        drive(0, 1'b1, 1'b1, 1'b0, 32'h100, 4'hF, 32'h0);
        drive(1, 1'b1, 1'b0, 1'b0, 32'h204, 4'hF, 32'h0);
        #1;
        checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL release_lock_gnt got=%b exp=%b", gnt, 2'b01); end
        @(negedge clk);
        drive(0, 1'b0, 1'b0, 1'b0, 32'h100, 4'hF, 32'h0);
        #1;
        checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL release_drop_gnt got=%b exp=%b", gnt, 2'b00); end
        checks++; if (rvalid !== 2'b01) begin errors++; $display("FAIL release_rvalid0 got=%b exp=%b", rvalid, 2'b01); end
        @(negedge clk);
        #1;
        checks++; if (gnt !== 2'b10) begin errors++; $display("FAIL release_p1_gnt got=%b exp=%b", gnt, 2'b10); end
        checks++; if (rvalid !== 2'b00) begin errors++; $display("FAIL release_rvalid1 got=%b exp=%b", rvalid, 2'b00); end
        @(negedge clk);
        idle();
        #1;
        checks++; if (rvalid !== 2'b10) begin errors++; $display("FAIL release_rvalid2 got=%b exp=%b", rvalid, 2'b10); end
        @(negedge clk);
        $display("test_lock_release done");
    endtask

    task automatic test_reset_mid_read();
        // Locked read by port 0, then reset in the response cycle.
        drive(0, 1'b1, 1'b1, 1'b0, 32'h100, 4'hF, 32'h0);
        #1;
        checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL rst_mid_gnt got=%b exp=%b", gnt, 2'b01); end
        @(negedge clk);
        rst_n = 1'b0;
        idle();
        drive(1, 1'b1, 1'b0, 1'b0, 32'h204, 4'hF, 32'h0);
        #1;
        checks++; if (rvalid !== 2'b00) begin errors++; $display("FAIL rst_mid_rvalid got=%b exp=%b", rvalid, 2'b00); end
        checks++; if (gnt !== 2'b00 || mem_en !== 1'b0) begin errors++; $display("FAIL rst_mid_gnt_en got=%b/%b exp=00/0", gnt, mem_en); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_mid_err got=%b exp=0", err); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++; if (gnt !== 2'b10) begin errors++; $display("FAIL rst_after_gnt got=%b exp=%b", gnt, 2'b10); end
        checks++; if (rvalid !== 2'b00) begin errors++; $display("FAIL rst_after_rvalid got=%b exp=%b", rvalid, 2'b00); end
        @(negedge clk);
        idle();
        #1;
        checks++; if (rvalid !== 2'b10) begin errors++; $display("FAIL rst_after_resp got=%b exp=%b", rvalid, 2'b10); end
        @(negedge clk);
        // Port 0 grant moves rr_ptr to 1; reset must bring it back to 0.
        drive(0, 1'b1, 1'b0, 1'b0, 32'h100, 4'hF, 32'h0);
        @(negedge clk);
        rst_n = 1'b0;
        idle();
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 1'b1, 1'b0, 1'b0, 32'h100, 4'hF, 32'h0);
        drive(1, 1'b1, 1'b0, 1'b0, 32'h204, 4'hF, 32'h0);
        #1;
        checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL rst_rr_ptr_gnt got=%b exp=%b", gnt, 2'b01); end
        @(negedge clk);
        idle();
        @(negedge clk);
        $display("test_reset_mid_read done");
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_contention();
        test_out_of_range();
        test_write_readback();
        test_lock_bound();
        test_lock_release();
        test_reset_mid_read();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
